spi_target: RTL
===============

Name: spi_target

Overview:
SPI peripheral-side (target) engine, the far end of the team's SPI controller. It receives spi_clk, chip select and MOSI from an external controller and drives MISO back, oversampling all SPI pins on the system clock. It exchanges words with the local logic through a one-deep TX holding register and a one-deep RX holding register. Word length and SPI mode match the controller's control-register encoding: length = word_size+1, mode = {cpol, cpha}, MSB first.

Parameters:
SYNC_STAGES, 2, synchronizer flops on spi_clk, spi_cs_n and spi_mosi (minimum 2)

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high reset
enable  input  1  block enable; 0 holds the FSM in IDLE
cpol  input  1  clock polarity (idle level of spi_clk)
cpha  input  1  clock phase
word_size  input  5  bits per word minus 1 (0..31)
spi_clk  input  1  SPI clock from the controller (asynchronous)
spi_cs_n  input  1  chip select, active low (asynchronous)
spi_mosi  input  1  controller-to-target data (asynchronous)
spi_miso  output  1  target-to-controller data
spi_miso_oe  output  1  MISO output enable; 1 only while ACTIVE
tx_data  input  32  word to transmit, right-justified
tx_write  input  1  single-cycle strobe that loads tx_data into the holding register
tx_full  output  1  TX holding register occupied
rx_data  output  32  last received word, right-justified, upper bits zero
rx_valid  output  1  rx_data holds an unread word
rx_read  input  1  single-cycle strobe that consumes rx_data
tx_underflow  output  1  sticky: a word was started while tx_full=0
rx_overflow  output  1  sticky: a word completed while rx_valid=1 and no rx_read
frame_abort  output  1  sticky: CS deasserted, or enable dropped, mid-word
clear_flags  input  1  single-cycle strobe that clears all three sticky flags
busy  output  1  FSM in ACTIVE

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, tx_full=0, rx_data=0, rx_valid=0, all sticky flags=0, busy=0, FSM=IDLE, synchronizers=idle (cs_n=1, clk=0).
- Pin handling: all three SPI pins pass through SYNC_STAGES flops. One further flop on spi_clk gives edge detection.
- Timing limit: each spi_clk phase must last at least 4 clk cycles.
- Edge roles: sample edge is rising when cpol^cpha=0, otherwise falling. Shift edge is the opposite edge.
- Frame latch: cpol, cpha and word_size are latched at CS assertion and held for the whole frame.
- FSM IDLE -> ACTIVE: on a synchronized falling edge of cs_n while enable=1.
  - in_cnt <= word_size; rx_shift <= 0.
  - tx_shift <= holding word if tx_full, else 0 with tx_underflow set.
  - tx_full cleared when the holding word is taken.
  - first_edge <= cpha.
- A cs_n already low when enable rises is ignored until cs_n has gone high and then low again.
- ACTIVE, on each sample edge: rx_shift <= {rx_shift[30:0], mosi_sync}; in_cnt decrements.
- ACTIVE, when the sample edge falls with in_cnt==0 (word complete):
  - The word is delivered to the RX holding register (rules below).
  - in_cnt reloads to word_size; rx_shift clears.
  - tx_shift reloads from the holding register with the same underflow rule; first_edge <= 1.
  - Back-to-back words within one CS are supported.
- ACTIVE, on each shift edge: if first_edge=1, clear it and do not shift; otherwise tx_shift <= tx_shift<<1.
- MISO: spi_miso = tx_shift[word_size_latched] while ACTIVE, 0 in IDLE.
  - mode 0/2: the MSB is valid within 1 clk of the synchronized CS fall.
  - mode 1/3: the MSB is valid from the first shift edge.
- RX delivery:
  - rx_valid=0: rx_data <= word; rx_valid <= 1.
  - rx_valid=1 with rx_read in the same cycle: rx_data <= new word; rx_valid stays 1; no overflow.
  - rx_valid=1 without rx_read: the new word is dropped, old rx_data is kept, rx_overflow set.
- rx_read while rx_valid=1 clears rx_valid the next cycle. rx_read while rx_valid=0 is ignored.
- Latency: rx_valid rises at most 4 clk cycles after the final sample edge at the pin.
- TX holding register:
  - tx_write while tx_full=0: capture tx_data, tx_full <= 1.
  - tx_write while tx_full=1: ignored, unless the holding word is consumed that same cycle; then tx_data is captured and tx_full stays 1.
- ACTIVE -> IDLE: on synchronized cs_n rising or enable=0.
  - If in_cnt != word_size latched (a partial word is in flight): the partial word is discarded and frame_abort is set.
  - tx_shift is discarded; the holding register is untouched.
  - spi_miso_oe drops the same cycle.
- clear_flags clears all sticky flags. A set event in the same cycle as clear_flags wins (flag ends up 1).
- reset mid-frame: everything returns to reset values the next cycle. The remainder of the current CS frame is ignored until cs_n goes high, then low again.
- busy = (FSM==ACTIVE).

Test Plan:
- Mode 0, word_size=7, tx_write 0xA5 before CS; controller sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1 on successive rising edges; rx_data=0x0000003C; rx_valid=1; tx_full=0; no flags.
- Mode 3, word_size=15, two back-to-back words in one CS with 0x1234 then 0xBEEF written (second written after the first is consumed); controller sends 0xCAFE, 0x0F0F -> MISO 0x1234 then 0xBEEF; two rx_valid events with rx_read between them; rx_data=0x0000CAFE, then 0x00000F0F.
- Underflow, mode 1, word_size=7, no tx_write -> MISO all 0; tx_underflow=1; rx still received correctly; clear_flags -> tx_underflow=0.
- Overflow, two 8-bit words 0x11, 0x22 with no rx_read -> rx_data=0x11, rx_overflow=1. Repeat with rx_read pulsed on the second completion cycle -> rx_data=0x22, rx_overflow=0.
- Abort, mode 0, word_size=7: CS raised after 5 clocks -> frame_abort=1, rx_valid=0, busy=0 next cycle. The next full frame receives correctly.
- reset pulsed mid-word -> all outputs at reset values; the rest of the frame is ignored; the next CS frame works normally.

Source files
------------

// File: rtl/spi_target.sv
// SPI target engine: oversamples spi_clk/cs_n/mosi on clk, shifts MSB-first words
// of word_size+1 bits, and exchanges them through one-deep TX and RX holding registers.
module spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cpol,
  input  logic        cpha,
  input  logic [4:0]  word_size,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [31:0] tx_data,
  input  logic        tx_write,
  output logic        tx_full,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_read,
  output logic        tx_underflow,
  output logic        rx_overflow,
  output logic        frame_abort,
  input  logic        clear_flags,
  output logic        busy
);

  // Handshakes: tx_write, rx_read and clear_flags are single-cycle strobes sampled
  // on posedge clk; tx_full/rx_valid are level flags owned by this block.
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] clk_sync, cs_sync, mosi_sync;
  logic [SYNC_STAGES:0]   settle;
  logic        clk_prev, cs_prev, cs_armed;
  logic        clk_s, cs_s, mosi_s;
  logic        clk_rise, clk_fall, cs_fall;
  logic        cpol_l, cpha_l;
  logic [4:0]  ws_l, in_cnt;
  logic [31:0] tx_shift, tx_hold, rx_word;
  logic [30:0] rx_shift;
  logic        first_edge, pend_und;
  logic        start, stop, active_run, sample_edge, shift_edge;
  logic        word_done, take_word, und_set;

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev;
  assign clk_fall = ~clk_s & clk_prev;
  assign cs_fall  = cs_armed & cs_prev & ~cs_s;

  // cs_armed stays low until cs_n has been seen high on the real pin after reset,
  // so a frame already in progress at reset release is never joined halfway.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      settle    <= '0;
      clk_prev  <= 1'b0;
      cs_prev   <= 1'b1;
      cs_armed  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
      clk_prev  <= clk_s;
      cs_prev   <= cs_s;
      if (settle[SYNC_STAGES] && cs_s) cs_armed <= 1'b1;
    end
  end

  assign sample_edge = (cpol_l ^ cpha_l) ? clk_fall : clk_rise;
  assign shift_edge  = (cpol_l ^ cpha_l) ? clk_rise : clk_fall;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    stop       = 1'b0;
    case (state)
      IDLE: begin
        if (enable && cs_fall) begin
          start      = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!enable || cs_s) begin
          stop       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign busy        = (state == ACTIVE);
  assign spi_miso_oe = busy;
  assign spi_miso    = busy ? tx_shift[ws_l] : 1'b0;
  assign active_run  = busy && !stop;
  assign word_done   = active_run && sample_edge && (in_cnt == 5'd0);
  assign take_word   = start || word_done;
  assign rx_word     = {rx_shift, mosi_s};
  // An empty reload at word end only counts as underflow once the next word really starts.
  assign und_set     = (start && !tx_full) || (active_run && sample_edge && pend_und);

  always_ff @(posedge clk) begin
    if (reset) begin
      cpol_l     <= 1'b0;
      cpha_l     <= 1'b0;
      ws_l       <= '0;
      in_cnt     <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      first_edge <= 1'b0;
      pend_und   <= 1'b0;
    end else begin
      if (start) begin
        cpol_l     <= cpol;
        cpha_l     <= cpha;
        ws_l       <= word_size;
        in_cnt     <= word_size;
        rx_shift   <= '0;
        tx_shift   <= tx_full ? tx_hold : '0;
        first_edge <= cpha;
      end else if (stop) begin
        tx_shift <= '0;
      end else if (busy) begin
        if (sample_edge) begin
          if (in_cnt == 5'd0) begin
            in_cnt     <= ws_l;
            rx_shift   <= '0;
            tx_shift   <= tx_full ? tx_hold : '0;
            first_edge <= 1'b1;
          end else begin
            rx_shift <= rx_word[30:0];
            in_cnt   <= in_cnt - 5'd1;
          end
        end else if (shift_edge) begin
          if (first_edge) first_edge <= 1'b0;
          else            tx_shift   <= {tx_shift[30:0], 1'b0};
        end
      end
      if (word_done)                     pend_und <= !tx_full;
      else if (!active_run || sample_edge) pend_und <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_hold <= '0;
      tx_full <= 1'b0;
    end else if (tx_write && (!tx_full || take_word)) begin
      tx_hold <= tx_data;
      tx_full <= 1'b1;
    end else if (take_word) begin
      tx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (word_done && (!rx_valid || rx_read)) begin
      rx_data  <= rx_word;
      rx_valid <= 1'b1;
    end else if (rx_read) begin
      rx_valid <= 1'b0;
    end
  end

  // A set event in the same cycle as clear_flags wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_underflow <= 1'b0;
      rx_overflow  <= 1'b0;
      frame_abort  <= 1'b0;
    end else begin
      tx_underflow <= (tx_underflow & ~clear_flags) | und_set;
      rx_overflow  <= (rx_overflow & ~clear_flags) | (word_done & rx_valid & ~rx_read);
      frame_abort  <= (frame_abort & ~clear_flags) | (stop & (in_cnt != ws_l));
    end
  end

endmodule
